// File: rtl/peak_note_tracker.sv
// Peak-bin to note quantiser with run-length stability filter and packed note history
// feeding the note-display sprite.
module peak_note_tracker #(
   parameter int unsigned BIN_WIDTH    = 12,
   parameter int unsigned NUM_NOTES    = 36,
   parameter int unsigned HISTORY      = 160,
   parameter int unsigned STABLE_COUNT = 4,
   parameter string       INIT_FILE    = "",
   parameter int unsigned BIN_BASE     = 8,
   parameter int unsigned BIN_STEP     = 4
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic [BIN_WIDTH-1:0]   peak_in,
   input  logic                   peak_valid_in,
   input  logic                   record_in,
   input  logic                   clear_in,
   output logic [5:0]             note_out,
   output logic                   note_valid_out,
   output logic                   commit_out,
   output logic [HISTORY*6-1:0]   notes_out,
   output logic                   busy_out,
   output logic                   dropped_out
);

   localparam int unsigned RunW    = $clog2(STABLE_COUNT + 1);
   localparam logic [5:0]  LastIdx = 6'(NUM_NOTES - 1);

   typedef enum logic [1:0] {StIdle, StFetch, StCmp, StDone} state_e;

   state_e                    state_q, state_d;
   logic [BIN_WIDTH-1:0]      peak_q, peak_d;
   logic [5:0]                idx_q, idx_d;
   logic [5:0]                result_q, result_d;
   logic [5:0]                cand_q, cand_d;
   logic [RunW-1:0]           run_q, run_d;
   logic [RunW-1:0]           run_inc;
   logic                      dropped_q, dropped_d;
   logic [HISTORY-1:0][5:0]   hist_q, hist_d;
   logic [BIN_WIDTH-1:0]      thr_q;
   logic                      stable_hit;

   function automatic logic [BIN_WIDTH-1:0] lin_thr(input logic [5:0] k);
      logic [63:0] v;
      logic [63:0] lim;
      v   = 64'(BIN_BASE) + 64'(k) * 64'(BIN_STEP);
      lim = (64'd1 << BIN_WIDTH) - 64'd1;
      if (v > lim) v = lim;
      return v[BIN_WIDTH-1:0];
   endfunction

   // Synchronous-read threshold ROM, addressed by idx_q; data is valid in CMP.
   always_ff @(posedge clk_in) begin
      thr_q <= lin_thr(idx_q);
   end

   always_comb begin
      state_d    = state_q;
      peak_d     = peak_q;
      idx_d      = idx_q;
      result_d   = result_q;
      cand_d     = cand_q;
      run_d      = run_q;
      dropped_d  = dropped_q;
      hist_d     = hist_q;
      run_inc    = (result_q == cand_q && run_q != '0) ? RunW'(run_q + 1'b1) : RunW'(1);
      stable_hit = (run_inc == RunW'(STABLE_COUNT));

      if (clear_in) begin
         state_d   = StIdle;
         run_d     = '0;
         cand_d    = '0;
         dropped_d = 1'b0;
         hist_d    = '0;
      end else begin
         if (peak_valid_in && state_q != StIdle) dropped_d = 1'b1;
         unique case (state_q)
            StIdle: begin
               if (peak_valid_in) begin
                  peak_d  = peak_in;
                  idx_d   = '0;
                  state_d = StFetch;
               end
            end
            StFetch: state_d = StCmp;
            StCmp: begin
               if (thr_q > peak_q) begin
                  result_d = idx_q;
                  state_d  = StDone;
               end else if (idx_q == LastIdx) begin
                  result_d = 6'(NUM_NOTES);
                  state_d  = StDone;
               end else begin
                  idx_d   = 6'(idx_q + 6'd1);
                  state_d = StFetch;
               end
            end
            StDone: begin
               state_d = StIdle;
               cand_d  = result_q;
               if (stable_hit) begin
                  run_d = '0;
                  if (record_in) hist_d = {hist_q[HISTORY-2:0], result_q};
               end else begin
                  run_d = run_inc;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q   <= StIdle;
         peak_q    <= '0;
         idx_q     <= '0;
         result_q  <= '0;
         cand_q    <= '0;
         run_q     <= '0;
         dropped_q <= 1'b0;
         hist_q    <= '0;
      end else begin
         state_q   <= state_d;
         peak_q    <= peak_d;
         idx_q     <= idx_d;
         result_q  <= result_d;
         cand_q    <= cand_d;
         run_q     <= run_d;
         dropped_q <= dropped_d;
         hist_q    <= hist_d;
      end
   end

   // A clear landing in DONE aborts the lookup, so the strobes are masked too.
   assign note_valid_out = (state_q == StDone) && !clear_in;
   assign commit_out     = note_valid_out && stable_hit && record_in;
   assign note_out       = result_q;
   assign notes_out      = hist_q;
   assign busy_out       = (state_q != StIdle);
   assign dropped_out    = dropped_q;

endmodule

// File: tb/tb_peak_note_tracker.sv
// Scoreboard bench for peak_note_tracker: stimulus queues expected lookups, a monitor
// checks note, commit and latency on every note_valid_out strobe.
module tb_peak_note_tracker;

   localparam int HIST = 160;

   logic              clk_in = 1'b0;
   logic              rst_in;
   logic [11:0]       peak_in;
   logic              peak_valid_in;
   logic              record_in;
   logic              clear_in;
   logic [5:0]        note_out;
   logic              note_valid_out;
   logic              commit_out;
   logic [HIST*6-1:0] notes_out;
   logic              busy_out;
   logic              dropped_out;

   typedef struct {
      logic [5:0] note;
      logic       commit;
      int         issue;
      int         lat;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   peak_note_tracker dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .peak_in        (peak_in),
      .peak_valid_in  (peak_valid_in),
      .record_in      (record_in),
      .clear_in       (clear_in),
      .note_out       (note_out),
      .note_valid_out (note_valid_out),
      .commit_out     (commit_out),
      .notes_out      (notes_out),
      .busy_out       (busy_out),
      .dropped_out    (dropped_out)
   );

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_idle(input int budget);
      int n;
      for (n = 0; n < budget; n++) begin
         @(negedge clk_in);
         if (!busy_out && sb.size() == 0) break;
      end
      if (n == budget) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: busy=%0b pending=%0d after %0d cycles",
                  busy_out, sb.size(), budget);
      end
   endtask

   task automatic issue(input logic [11:0] pk, input logic [5:0] note, input logic commit,
                        input int lat, input int gap);
      exp_t e;
      @(negedge clk_in);
      peak_valid_in = 1'b1;
      peak_in       = pk;
      e.note = note; e.commit = commit; e.issue = cyc; e.lat = lat;
      sb.push_back(e);
      @(negedge clk_in);
      peak_valid_in = 1'b0;
      wait_idle(400);
      repeat (gap) @(negedge clk_in);
   endtask

   task automatic start_unchecked(input logic [11:0] pk);
      @(negedge clk_in);
      peak_valid_in = 1'b1;
      peak_in       = pk;
      @(negedge clk_in);
      peak_valid_in = 1'b0;
   endtask

   task automatic pulse_clear();
      @(negedge clk_in);
      clear_in = 1'b1;
      @(negedge clk_in);
      clear_in = 1'b0;
   endtask

   initial begin
      exp_t e;
      rst_in        = 1'b1;
      peak_in       = '0;
      peak_valid_in = 1'b0;
      record_in     = 1'b0;
      clear_in      = 1'b0;
      fork
         begin : monitor
            forever begin
               @(posedge clk_in);
               #1;
               if (note_valid_out !== 1'b0) begin
                  if (sb.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL stray_strobe: note_valid_out=%0b note=%0d at cycle %0d",
                              note_valid_out, note_out, cyc);
                  end else begin
                     e = sb.pop_front();
                     chk("note", 64'(note_out), 64'(e.note));
                     chk("commit", 64'(commit_out), 64'(e.commit));
                     chk("latency", 64'(cyc - e.issue), 64'(e.lat));
                  end
               end else if (commit_out !== 1'b0) begin
                  checks++;
                  errors++;
                  $display("FAIL lone_commit: commit_out=%0b without note_valid_out at %0d",
                           commit_out, cyc);
               end
            end
         end
         begin : stimulus
            int bad;
            logic [5:0] n;
            repeat (3) @(negedge clk_in);
            rst_in = 1'b0;
            @(negedge clk_in);
            chk("rst_note", 64'(note_out), 0);
            chk("rst_valid", 64'(note_valid_out), 0);
            chk("rst_commit", 64'(commit_out), 0);
            chk("rst_busy", 64'(busy_out), 0);
            chk("rst_dropped", 64'(dropped_out), 0);
            chk("rst_notes", 64'(|notes_out), 0);

            // Single lookups: boundary below table, first entry, mid, saturating top.
            issue(12'd7,    6'd0,  1'b0, 3,  2);
            issue(12'd8,    6'd1,  1'b0, 5,  2);
            issue(12'd19,   6'd3,  1'b0, 9,  2);
            issue(12'd4095, 6'd36, 1'b0, 73, 2);

            // Stable run with record low: run wraps, history untouched.
            issue(12'd20, 6'd4, 1'b0, 11, 0);
            issue(12'd20, 6'd4, 1'b0, 11, 0);
            issue(12'd20, 6'd4, 1'b0, 11, 0);
            issue(12'd20, 6'd4, 1'b0, 11, 0);
            chk("norec_notes", 64'(|notes_out), 0);

            record_in = 1'b1;
            for (int i = 0; i < 8; i++) issue(12'd20, 6'd4, (i % 4) == 3, 11, 88);
            chk("hist0", 64'(notes_out[5:0]), 4);
            chk("hist1", 64'(notes_out[11:6]), 4);
            chk("hist2", 64'(notes_out[17:12]), 0);
            issue(12'd20, 6'd4, 1'b0, 11, 0);
            issue(12'd20, 6'd4, 1'b0, 11, 0);
            issue(12'd20, 6'd4, 1'b0, 11, 0);
            issue(12'd40, 6'd9, 1'b0, 21, 0);
            issue(12'd20, 6'd4, 1'b0, 11, 0);
            chk("hist0_hold", 64'(notes_out[5:0]), 4);

            // 161 commits with notes rotating 1..10; peak 4+4n maps to note n.
            pulse_clear();
            for (int g = 0; g < HIST + 1; g++) begin
               n = 6'((g % 10) + 1);
               for (int k = 0; k < 4; k++)
                  issue(12'(4 + 4 * int'(n)), n, k == 3, 2 * int'(n) + 3, 0);
            end
            chk("hist_newest", 64'(notes_out[5:0]), 64'((HIST % 10) + 1));
            chk("hist_nox", 64'($isunknown(notes_out)), 0);
            bad = 0;
            for (int j = 0; j < HIST; j++)
               if (notes_out[j*6 +: 6] !== 6'(((HIST - j) % 10) + 1)) bad++;
            chk("hist_all_slots", 64'(bad), 0);

            // Drop while busy; the running search must still complete.
            record_in = 1'b0;
            @(negedge clk_in);
            peak_valid_in = 1'b1;
            peak_in       = 12'd4095;
            e.note = 6'd36; e.commit = 1'b0; e.issue = cyc; e.lat = 73;
            sb.push_back(e);
            @(negedge clk_in);
            peak_valid_in = 1'b0;
            @(negedge clk_in);
            peak_valid_in = 1'b1;
            peak_in       = 12'd100;
            @(negedge clk_in);
            peak_valid_in = 1'b0;
            wait_idle(400);
            chk("dropped_set", 64'(dropped_out), 1);
            pulse_clear();
            chk("clr_dropped", 64'(dropped_out), 0);
            chk("clr_notes", 64'(|notes_out), 0);
            chk("clr_keeps_note", 64'(note_out), 36);

            // Clear mid-search aborts with no strobe.
            start_unchecked(12'd4095);
            repeat (6) @(negedge clk_in);
            pulse_clear();
            chk("clr_abort_busy", 64'(busy_out), 0);
            repeat (100) @(negedge clk_in);
            chk("clr_abort_idle", 64'(busy_out), 0);

            // Asynchronous reset off a clock edge mid-search.
            start_unchecked(12'd4095);
            repeat (10) @(negedge clk_in);
            #3;
            rst_in = 1'b1;
            #1;
            chk("arst_busy", 64'(busy_out), 0);
            chk("arst_note", 64'(note_out), 0);
            chk("arst_valid", 64'(note_valid_out), 0);
            repeat (2) @(negedge clk_in);
            rst_in = 1'b0;
            repeat (100) @(negedge clk_in);
            chk("arst_idle", 64'(busy_out), 0);
         end
      join_any
      chk("sb_drained", 64'(sb.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
